// File: rtl/ram_dump_reader_if.sv
// Bus bundle for ram_dump_reader: start/status, RAM program-address read port and byte stream.
// The slave view is the dump engine; the master view is whoever drives start, RAM data and ready.
interface ram_dump_reader_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  i_start;
  logic                  o_busy;
  logic                  o_done;
  logic [ADDR_WIDTH-1:0] o_ram_address;
  logic                  o_ram_read_enable;
  logic [15:0]           i_ram_data;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;

  modport slave (
    input  i_start, i_ram_data, i_tx_ready,
    output o_busy, o_done, o_ram_address, o_ram_read_enable, o_tx_data, o_tx_valid
  );

  modport master (
    output i_start, i_ram_data, i_tx_ready,
    input  o_busy, o_done, o_ram_address, o_ram_read_enable, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/ram_dump_reader.sv
// Walks the program RAM from address 0 and streams each word as hi/lo bytes on valid/ready.
// Define RAM_DUMP_CHECKSUM_EN to append an 8-bit mod-256 sum of all sent bytes.
//
// state   | meaning
// IDLE    | waiting for i_start
// READ    | RAM word at counter captured into word register
// SEND_HI | offering word[15:8]
// SEND_LO | offering word[7:0], then next word or finish
// SUM     | offering checksum byte (checksum build only)
// DONE    | one-cycle completion pulse
module ram_dump_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_COUNT = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  ram_dump_reader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    SEND_HI = 3'd2,
    SEND_LO = 3'd3,
`ifdef RAM_DUMP_CHECKSUM_EN
    SUM     = 3'd4,
`endif
    DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           word_q, word_d;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [7:0]            tx_data;
  logic                  tx_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
`ifdef RAM_DUMP_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    addr_out = '0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = READ;
          addr_d  = '0;
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      READ: begin
        busy     = 1'b1;
        rd_en    = 1'b1;
        addr_out = addr_q;
        word_d   = bus.i_ram_data;
        state_d  = SEND_HI;
      end
      SEND_HI: begin
        busy     = 1'b1;
        addr_out = addr_q;
        tx_valid = 1'b1;
        tx_data  = word_q[15:8];
        if (bus.i_tx_ready) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_d   = sum_q + tx_data;
`endif
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        busy     = 1'b1;
        addr_out = addr_q;
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (bus.i_tx_ready) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_d = sum_q + tx_data;
`endif
          // Counter stops on the last word so it never wraps past WORD_COUNT-1.
          if (addr_q == LAST_ADDR) begin
`ifdef RAM_DUMP_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = READ;
          end
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      SUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = sum_q;
        if (bus.i_tx_ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_busy            = busy;
  assign bus.o_done            = done;
  assign bus.o_ram_read_enable = rd_en;
  assign bus.o_ram_address     = addr_out;
  assign bus.o_tx_data         = tx_data;
  assign bus.o_tx_valid        = tx_valid;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: table-driven RAM loads, byte scoreboard,
// hand-written sequences for latency, backpressure, start handling and mid-dump reset.
module tb_ram_dump_reader;

`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int TOTAL = 33;
  localparam int BUSY_CYCLES = 49;
`else
  localparam int TOTAL = 32;
  localparam int BUSY_CYCLES = 48;
`endif

  typedef struct {
    logic [15:0] word;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [15:0] ram [0:15];
  vec_t load_a [0:15];
  vec_t load_b [0:15];
  logic [7:0] exp_q [$];

  int checks;
  int failures;
  int byte_cnt;
  bit prev_xfer;
  bit prev_stall;
  logic [7:0] prev_data;

  ram_dump_reader_if #(.ADDR_WIDTH(4)) bus ();

  ram_dump_reader #(.ADDR_WIDTH(4), .WORD_COUNT(16)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  assign bus.i_ram_data = ram[bus.o_ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},  {31'd0, bus.o_busy}, 0);
    check({name, "_done"},  {31'd0, bus.o_done}, 0);
    check({name, "_addr"},  {28'd0, bus.o_ram_address}, 0);
    check({name, "_rden"},  {31'd0, bus.o_ram_read_enable}, 0);
    check({name, "_data"},  {24'd0, bus.o_tx_data}, 0);
    check({name, "_valid"}, {31'd0, bus.o_tx_valid}, 0);
  endtask

  task automatic load_ram(input bit sel_b);
    for (int i = 0; i < 16; i++) ram[i] = sel_b ? load_b[i].word : load_a[i].word;
  endtask

  task automatic push_expected(input bit sel_b);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = sel_b ? load_b[i] : load_a[i];
      exp_q.push_back(v.exp_hi);
      exp_q.push_back(v.exp_lo);
      sum = sum + v.exp_hi + v.exp_lo;
    end
`ifdef RAM_DUMP_CHECKSUM_EN
    if (sel_b) exp_q.push_back(sum);
    else       exp_q.push_back(8'h8B);
`endif
  endtask

  // Start sampled at edge n: READ at address 0 in cycle n+1, first byte valid in cycle n+2.
  task automatic start_dump(input bit hold);
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 if (!hold) bus.i_start = 1'b0;
    @(negedge clk);
    check("lat_read_en", {31'd0, bus.o_ram_read_enable}, 1);
    check("lat_read_addr", {28'd0, bus.o_ram_address}, 0);
    check("lat_no_valid_yet", {31'd0, bus.o_tx_valid}, 0);
    check("lat_busy", {31'd0, bus.o_busy}, 1);
    @(negedge clk);
    check("lat_first_valid", {31'd0, bus.o_tx_valid}, 1);
  endtask

  task automatic wait_done(input bit rand_rdy, input int budget, output int busy_cycles);
    bit found;
    found = 1'b0;
    busy_cycles = 2;
    for (int c = 0; c < budget; c++) begin
      if (rand_rdy) begin
        @(posedge clk); #1 bus.i_tx_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.o_done) begin
        found = 1'b1;
        break;
      end
      if (bus.o_busy) busy_cycles++;
    end
    check("done_seen", {31'd0, found}, 1);
    if (rand_rdy) begin
      @(posedge clk); #1 bus.i_tx_ready = 1'b1;
    end
  endtask

  // Byte scoreboard plus handshake-rule checks, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        byte_cnt = 0;
        prev_xfer = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("bp_valid_hold", {31'd0, bus.o_tx_valid}, 1);
          check("bp_data_hold", {24'd0, bus.o_tx_data}, {24'd0, prev_data});
        end
        if (!bus.o_tx_valid) check("data_zero_when_idle", {24'd0, bus.o_tx_data}, 0);
        if (bus.o_done) begin
          check("done_after_last_byte", {31'd0, prev_xfer}, 1);
          check("bytes_per_dump", byte_cnt, TOTAL);
          check("busy_low_in_done", {31'd0, bus.o_busy}, 0);
          byte_cnt = 0;
        end
        if (bus.o_tx_valid && bus.i_tx_ready) begin
          byte_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_byte actual=%0h required=none", bus.o_tx_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, e});
          end
        end
        prev_xfer = bus.o_tx_valid && bus.i_tx_ready;
        prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
        prev_data = bus.o_tx_data;
      end
    end
  end

  initial begin
    int bc;
    bit found;
    checks = 0;
    failures = 0;
    byte_cnt = 0;

    load_a[0] = '{16'h00FF, 8'h00, 8'hFF};
    load_a[1] = '{16'h017F, 8'h01, 8'h7F};
    load_a[2] = '{16'h0201, 8'h02, 8'h01};
    load_a[3] = '{16'h0702, 8'h07, 8'h02};
    for (int i = 4; i < 16; i++) load_a[i] = '{16'h0000, 8'h00, 8'h00};

    load_b[0]  = '{16'hA55A, 8'hA5, 8'h5A};
    load_b[1]  = '{16'h1234, 8'h12, 8'h34};
    load_b[2]  = '{16'hFFFF, 8'hFF, 8'hFF};
    load_b[3]  = '{16'h8000, 8'h80, 8'h00};
    load_b[4]  = '{16'h0001, 8'h00, 8'h01};
    load_b[5]  = '{16'hC3C3, 8'hC3, 8'hC3};
    load_b[6]  = '{16'h7E81, 8'h7E, 8'h81};
    load_b[7]  = '{16'h0F0F, 8'h0F, 8'h0F};
    load_b[8]  = '{16'hF0F0, 8'hF0, 8'hF0};
    load_b[9]  = '{16'hDEAD, 8'hDE, 8'hAD};
    load_b[10] = '{16'hBEEF, 8'hBE, 8'hEF};
    load_b[11] = '{16'h0100, 8'h01, 8'h00};
    load_b[12] = '{16'h00FE, 8'h00, 8'hFE};
    load_b[13] = '{16'h5AA5, 8'h5A, 8'hA5};
    load_b[14] = '{16'h4242, 8'h42, 8'h42};
    load_b[15] = '{16'h9999, 8'h99, 8'h99};

    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_tx_ready = 1'b1;
    load_ram(1'b0);
    #2 check_all_zero("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 2: spec load, ready tied high, exact busy length.
    push_expected(1'b0);
    start_dump(1'b0);
    wait_done(1'b0, 200, bc);
    check("busy_cycles", bc, BUSY_CYCLES);
    check("queue_empty_t2", exp_q.size(), 0);

    // Test 3: stall while 0x01 is offered.
    push_expected(1'b0);
    start_dump(1'b0);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.o_tx_valid && bus.o_tx_data == 8'h01) begin
        found = 1'b1;
        break;
      end
    end
    check("stall_byte_seen", {31'd0, found}, 1);
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.o_tx_valid}, 1);
      check("stall_data", {24'd0, bus.o_tx_data}, 32'h01);
    end
    @(posedge clk); #1 bus.i_tx_ready = 1'b1;
    wait_done(1'b0, 200, bc);
    check("queue_empty_t3", exp_q.size(), 0);

    // Test 4a: start pulsed mid-dump is ignored.
    push_expected(1'b0);
    start_dump(1'b0);
    repeat (10) @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    wait_done(1'b0, 200, bc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_restart_busy", {31'd0, bus.o_busy}, 0);
    end
    check("queue_empty_t4a", exp_q.size(), 0);

    // Test 4b: start held high gives back-to-back dumps from address 0.
    push_expected(1'b0);
    push_expected(1'b0);
    start_dump(1'b1);
    wait_done(1'b0, 200, bc);
    found = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.o_ram_read_enable) begin
        found = 1'b1;
        check("restart_addr", {28'd0, bus.o_ram_address}, 0);
        break;
      end
    end
    check("restart_seen", {31'd0, found}, 1);
    @(posedge clk); #1 bus.i_start = 1'b0;
    wait_done(1'b0, 200, bc);
    check("queue_empty_t4b", exp_q.size(), 0);

    // Test 5: reset after three bytes, then a clean re-dump.
    push_expected(1'b0);
    start_dump(1'b0);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (byte_cnt == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("three_bytes_offered", {31'd0, found}, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_dump");
    check("remaining_after_3", exp_q.size(), TOTAL - 3);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset_idle");
    push_expected(1'b0);
    start_dump(1'b0);
    wait_done(1'b0, 200, bc);
    check("queue_empty_t5", exp_q.size(), 0);

    // Second table: different load, steady and random backpressure.
    load_ram(1'b1);
    push_expected(1'b1);
    start_dump(1'b0);
    wait_done(1'b0, 200, bc);
    check("busy_cycles_b", bc, BUSY_CYCLES);
    check("queue_empty_b", exp_q.size(), 0);

    push_expected(1'b1);
    start_dump(1'b0);
    wait_done(1'b1, 1000, bc);
    check("queue_empty_b_rand", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
